multicycle_controller: RTL

//  Moore control FSM for the multi-cycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle RV32I controller and its datapath.
// Instruction fields and the zero flag flow in; mux selects, write enables and ALU control flow out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;
  logic       regwrite;

  // Handshake: none. Every output is a level that is valid for the whole cycle the
  // controller sits in a state; the datapath consumes it at the next rising edge.
  modport master (
    input  op, funct3, funct7b5, zero,
    output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           immsrc, alucontrol, regwrite
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           immsrc, alucontrol, regwrite
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Outputs decode from the state register; write enables are held low while reset_n is low.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_controller_if.master ctl,
  output logic [STATE_W-1:0]     state_o,
  output logic                   illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;

  logic       pcupdate, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;
  logic       adrsrc;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol, funct_alu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011)
      S_MEMADR:   state_d = ctl.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // sub only for R-type with funct7b5; addi with instr[30] set is still an add
  always_comb begin
    funct_alu = ALU_ADD;
    case (ctl.funct3)
      3'b000:  funct_alu = (ctl.op[5] & ctl.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    case (ctl.op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  always_comb begin
    pcupdate     = 1'b0;
    branch       = 1'b0;
    adrsrc       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (ctl.op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_raw = 1'b0;
          default:                                  illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        alusrca    = 2'b10;
        alucontrol = funct_alu;
      end
      S_EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = funct_alu;
      end
      S_ALUWB: regwrite_raw = 1'b1;
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
      end
      default: begin
        pcupdate = 1'b0;
      end
    endcase
  end

  // Gating with reset_n makes an asserted reset kill any write in the same instant
  assign ctl.pcwrite    = reset_n & (pcupdate | (branch & ctl.zero));
  assign ctl.irwrite    = reset_n & irwrite_raw;
  assign ctl.memwrite   = reset_n & memwrite_raw;
  assign ctl.regwrite   = reset_n & regwrite_raw;
  assign illegal        = reset_n & illegal_raw;
  assign ctl.adrsrc     = adrsrc;
  assign ctl.resultsrc  = resultsrc;
  assign ctl.alusrca    = alusrca;
  assign ctl.alusrcb    = alusrcb;
  assign ctl.immsrc     = immsrc;
  assign ctl.alucontrol = alucontrol;
  assign state_o        = state_q;

endmodule
